// File: rtl/poly_tile_feeder_if.sv
// Bus bundle for poly_tile_feeder: coefficient load port, job control and tile handshake.
// The slave modport is the feeder's view; the master modport is the driver/multiplier side.
interface poly_tile_feeder_if #(
  parameter int POLY_A_WIDTH      = 128,
  parameter int POLY_B_WIDTH      = 128,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8,
  parameter int DATA_WIDTH        = 64
);
  localparam int NA   = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
  localparam int NB   = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
  localparam int MAXW = (POLY_A_WIDTH > POLY_B_WIDTH) ? POLY_A_WIDTH : POLY_B_WIDTH;
  localparam int LAW  = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int IAW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int JAW  = (NB > 1) ? $clog2(NB) : 1;

  logic                                         load_en;
  logic                                         load_sel;
  logic [LAW-1:0]                               load_addr;
  logic [DATA_WIDTH-1:0]                        load_data;
  logic                                         start;
  logic                                         busy;
  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a;
  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b;
  logic                                         tile_valid;
  logic                                         tile_ack;
  logic [IAW-1:0]                               tile_a_index;
  logic [JAW-1:0]                               tile_b_index;
  logic                                         done;
  logic [31:0]                                  stall_cycles;

  modport master (
    output load_en, load_sel, load_addr, load_data, start, tile_ack,
    input  busy, tile_a, tile_b, tile_valid, tile_a_index, tile_b_index, done, stall_cycles
  );

  modport slave (
    input  load_en, load_sel, load_addr, load_data, start, tile_ack,
    output busy, tile_a, tile_b, tile_valid, tile_a_index, tile_b_index, done, stall_cycles
  );
endinterface

// File: rtl/poly_tile_feeder.sv
// Buffers polynomials A and B and walks every (A tile, B tile) pair for the tiled multiplier.
// Optional stall counter enabled by defining TILE_FEEDER_PERF_CNT_EN.
module poly_tile_feeder #(
  parameter int POLY_A_WIDTH      = 128,
  parameter int POLY_B_WIDTH      = 128,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8,
  parameter int DATA_WIDTH        = 64
) (
  input logic               clk,
  input logic               rst_n,
  poly_tile_feeder_if.slave bus
);
  localparam int NA  = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
  localparam int NB  = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
  localparam int AAW = (POLY_A_WIDTH > 1) ? $clog2(POLY_A_WIDTH) : 1;
  localparam int BAW = (POLY_B_WIDTH > 1) ? $clog2(POLY_B_WIDTH) : 1;
  localparam int IAW = (NA > 1) ? $clog2(NA) : 1;
  localparam int JAW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

  logic [DATA_WIDTH-1:0] memA [POLY_A_WIDTH];
  logic [DATA_WIDTH-1:0] memB [POLY_B_WIDTH];

  state_e                                       state_q;
  logic [IAW-1:0]                               aIdx_q, aIdx_d;
  logic [JAW-1:0]                               bIdx_q, bIdx_d;
  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tileA_q, tileA_d;
  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tileB_q, tileB_d;
  logic                                         tileValid_q, done_q, busy_q;
  logic                                         startOk, lastPair, issueNow;

  // A start that coincides with a load is dropped so the write wins.
  assign startOk  = (state_q == IDLE) && bus.start && !bus.load_en;
  assign lastPair = (int'(aIdx_q) == NA - 1) && (int'(bIdx_q) == NB - 1);
  assign issueNow = startOk || ((state_q == WAIT) && bus.tile_ack && !lastPair);

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && bus.load_en) begin
      if (!bus.load_sel && (int'(bus.load_addr) < POLY_A_WIDTH))
        memA[AAW'(bus.load_addr)] <= bus.load_data;
      if (bus.load_sel && (int'(bus.load_addr) < POLY_B_WIDTH))
        memB[BAW'(bus.load_addr)] <= bus.load_data;
    end
  end

  always_comb begin
    aIdx_d = aIdx_q;
    bIdx_d = bIdx_q;
    if (state_q == IDLE) begin
      aIdx_d = '0;
      bIdx_d = '0;
    end else if (int'(bIdx_q) == NB - 1) begin
      aIdx_d = aIdx_q + 1'b1;
      bIdx_d = '0;
    end else begin
      bIdx_d = bIdx_q + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < POLY_A_TILE_WIDTH; k++)
      tileA_d[k] = memA[AAW'(int'(aIdx_d) * POLY_A_TILE_WIDTH + k)];
    for (int k = 0; k < POLY_B_TILE_WIDTH; k++)
      tileB_d[k] = memB[BAW'(int'(bIdx_d) * POLY_B_TILE_WIDTH + k)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aIdx_q      <= '0;
      bIdx_q      <= '0;
      tileA_q     <= '0;
      tileB_q     <= '0;
      tileValid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tileValid_q <= 1'b0;
      done_q      <= 1'b0;
      if (issueNow) begin
        aIdx_q      <= aIdx_d;
        bIdx_q      <= bIdx_d;
        tileA_q     <= tileA_d;
        tileB_q     <= tileB_d;
        tileValid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (startOk) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (bus.tile_ack) begin
            if (lastPair) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TILE_FEEDER_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (startOk)
      stall_q <= '0;
    else if ((state_q == WAIT) && !bus.tile_ack && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.tile_a       = tileA_q;
  assign bus.tile_b       = tileB_q;
  assign bus.tile_a_index = aIdx_q;
  assign bus.tile_b_index = bIdx_q;
  assign bus.tile_valid   = tileValid_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_poly_tile_feeder.sv
// Directed bench for poly_tile_feeder: loads A[n]=n+1, B[n]=2n and checks tile walks, timing and reset.
// Stall-count expectations follow TILE_FEEDER_PERF_CNT_EN.
module tb_poly_tile_feeder;
  localparam int PAW = 128;
  localparam int PBW = 128;
  localparam int TA  = 8;
  localparam int TB  = 8;
  localparam int DW  = 64;
  localparam int NB  = PBW / TB;
  localparam int NPAIRS = (PAW / TA) * NB;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] modelA [PAW];
  logic [DW-1:0] modelB [PBW];

  int optAckDelay;
  bit optAckHigh;
  bit optAckInIssue;
  int optAbortAt;
  int optLoadAt;

  poly_tile_feeder_if #(
    .POLY_A_WIDTH(PAW), .POLY_B_WIDTH(PBW),
    .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB), .DATA_WIDTH(DW)
  ) bus ();

  poly_tile_feeder #(
    .POLY_A_WIDTH(PAW), .POLY_B_WIDTH(PBW),
    .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB), .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input bit sel, input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_sel  = sel;
    bus.load_addr = 7'(addr);
    bus.load_data = data;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, ".busy"},  64'(bus.busy), 0);
    checkOutput({tag, ".valid"}, 64'(bus.tile_valid), 0);
    checkOutput({tag, ".done"},  64'(bus.done), 0);
    checkOutput({tag, ".idxA"},  64'(bus.tile_a_index), 0);
    checkOutput({tag, ".idxB"},  64'(bus.tile_b_index), 0);
    checkOutput({tag, ".tileA0"}, bus.tile_a[0], 0);
    checkOutput({tag, ".tileB7"}, bus.tile_b[7], 0);
    checkOutput({tag, ".stall"}, 64'(bus.stall_cycles), 0);
  endtask

  task automatic checkPulse(input int p, input int t, input int spacing);
    int expI, expJ;
    expI = p / NB;
    expJ = p % NB;
    checkOutput("validCyc", 64'(t), 64'(1 + p * spacing));
    checkOutput("idxA", 64'(bus.tile_a_index), 64'(expI));
    checkOutput("idxB", 64'(bus.tile_b_index), 64'(expJ));
    for (int k = 0; k < TA; k++) checkOutput("tileA", bus.tile_a[k], modelA[expI * TA + k]);
    for (int k = 0; k < TB; k++) checkOutput("tileB", bus.tile_b[k], modelB[expJ * TB + k]);
  endtask

  // One job: start in cycle 0, ack per options, observe every cycle at the falling edge.
  task automatic applyStimulus(input string name);
    int  pulses, doneCyc, busyLow, spacing, lastValid, expDone;
    bit  seenDone;
    pulses = 0; doneCyc = -1; busyLow = 0; lastValid = -100; seenDone = 0;
    spacing = optAckHigh ? 2 : optAckDelay + 1;
    expDone = 1 + (NPAIRS - 1) * spacing + (optAckHigh ? 1 : optAckDelay) + 1;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.tile_ack = optAckHigh;
    for (int t = 1; t < 3000 && !seenDone; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.busy) busyLow++;
      if (bus.done) begin
        seenDone = 1;
        doneCyc  = t;
      end
      if (bus.tile_valid) begin
        checkPulse(pulses, t, spacing);
        if (pulses == optAbortAt) begin
          rst_n        = 1'b0;
          bus.tile_ack = 1'b0;
          #1;
          checkZeroOutputs({name, ".rstNow"});
          @(negedge clk);
          checkZeroOutputs({name, ".rstHeld"});
          rst_n = 1'b1;
          return;
        end
        pulses++;
        lastValid = t;
      end
      if (t == optLoadAt) begin
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b0;
        bus.load_addr = 7'd0;
        bus.load_data = 64'hFFFF;
      end else begin
        bus.load_en = 1'b0;
      end
      if (!optAckHigh)
        bus.tile_ack = (t == lastValid + optAckDelay) || (optAckInIssue && bus.tile_valid);
    end
    bus.tile_ack = 1'b0;
    checkOutput({name, ".pulses"},  64'(pulses), 64'(NPAIRS));
    checkOutput({name, ".doneCyc"}, 64'(doneCyc), 64'(expDone));
    checkOutput({name, ".busyLow"}, 64'(busyLow), 0);
`ifdef TILE_FEEDER_PERF_CNT_EN
    checkOutput({name, ".stall"}, 64'(bus.stall_cycles), optAckHigh ? 0 : 64'(NPAIRS * (optAckDelay - 1)));
`else
    checkOutput({name, ".stall"}, 64'(bus.stall_cycles), 0);
`endif
    @(negedge clk);
    checkOutput({name, ".busyDrop"}, 64'(bus.busy), 0);
    checkOutput({name, ".doneDrop"}, 64'(bus.done), 0);
    checkOutput({name, ".idxAHold"}, 64'(bus.tile_a_index), 15);
    checkOutput({name, ".idxBHold"}, 64'(bus.tile_b_index), 15);
  endtask

  task automatic checkIdleCycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.load_en  = 1'b0;
      bus.tile_ack = 1'b0;
      checkOutput({tag, ".valid"}, 64'(bus.tile_valid), 0);
      checkOutput({tag, ".busy"},  64'(bus.busy), 0);
      checkOutput({tag, ".idxA"},  64'(bus.tile_a_index), 15);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load_en = 1'b0; bus.load_sel = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.tile_ack = 1'b0;
    optAckDelay = 3; optAckHigh = 0; optAckInIssue = 0; optAbortAt = -1; optLoadAt = -1;
    repeat (2) @(negedge clk);
    checkZeroOutputs("reset");
    rst_n = 1'b1;

    for (int n = 0; n < PAW; n++) begin
      modelA[n] = 64'(n + 1);
      loadWord(1'b0, n, modelA[n]);
    end
    for (int n = 0; n < PBW; n++) begin
      modelB[n] = 64'(2 * n);
      loadWord(1'b1, n, modelB[n]);
    end
    @(negedge clk);
    bus.load_en = 1'b0;

    applyStimulus("ackDelay3");

    optAckHigh = 1;
    applyStimulus("ackHigh");
    optAckHigh = 0;

    @(negedge clk);
    bus.start = 1'b1; bus.load_en = 1'b1; bus.load_sel = 1'b0;
    bus.load_addr = 7'd5; bus.load_data = 64'hABCD;
    modelA[5] = 64'hABCD;
    checkIdleCycles("startWithLoad", 6);

    @(negedge clk);
    bus.tile_ack = 1'b1;
    checkIdleCycles("ackInIdle", 3);

    optAckInIssue = 1; optLoadAt = 5;
    applyStimulus("ackInIssue");
    optAckInIssue = 0; optLoadAt = -1;

    optAbortAt = 37;
    applyStimulus("abort");
    optAbortAt = -1;

    applyStimulus("afterReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/poly_tile_feeder.md
# poly_tile_feeder

- Upstream stage of the tiled polynomial multiplier.
- Buffers full input polynomials A and B, loaded one coefficient per cycle.
- Walks every (A tile, B tile) pair in a fixed order and presents each pair as `tile_a`/`tile_b` with a one-cycle valid pulse.
- After each pulse, waits for the multiplier's per-tile completion before issuing the next pair. Ends the job with a `done` pulse.

## Interface
- `POLY_A_WIDTH`, 128: coefficients in polynomial A.
- `POLY_B_WIDTH`, 128: coefficients in polynomial B.
- `POLY_A_TILE_WIDTH`, 8: coefficients per A tile. Must divide `POLY_A_WIDTH`.
- `POLY_B_TILE_WIDTH`, 8: coefficients per B tile. Must divide `POLY_B_WIDTH`.
- `DATA_WIDTH`, 64: coefficient width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `load_en`  in  1: write one coefficient this cycle.
- `load_sel`  in  1: write target, 0 = A, 1 = B.
- `load_addr`  in  $clog2(max(POLY_A_WIDTH,POLY_B_WIDTH)): coefficient index.
- `load_data`  in  DATA_WIDTH: coefficient value.
- `start`  in  1: begin a job.
- `busy`  out  1: high from the cycle after an accepted start until `done`, inclusive.
- `tile_a`  out  [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0]: A tile, registered.
- `tile_b`  out  [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0]: B tile, registered.
- `tile_valid`  out  1: one-cycle pulse marking a new tile pair. Drives the multiplier start.
- `tile_ack`  in  1: multiplier tile-complete strobe (its ready-for-tile).
- `tile_a_index`  out  $clog2(NA): A tile number of the current pair, NA = POLY_A_WIDTH/POLY_A_TILE_WIDTH.
- `tile_b_index`  out  $clog2(NB): B tile number of the current pair, NB = POLY_B_WIDTH/POLY_B_TILE_WIDTH.
- `done`  out  1: one-cycle pulse after the final ack.
- `stall_cycles`  out  32: see Configuration.

## Operation
**Storage**
- Two register arrays: A (`POLY_A_WIDTH` entries) and B (`POLY_B_WIDTH` entries).
- Arrays are not reset; contents survive reset.
- A write occurs when `load_en` is high and the FSM is in IDLE.
- Writes are ignored in any other state.
- Out-of-range `load_addr` values are ignored.

**Iteration order**
- Outer loop: i = 0..NA-1. Inner loop: j = 0..NB-1.
- For pair (i,j): `tile_a[k]` = A[i*POLY_A_TILE_WIDTH+k] and `tile_b[k]` = B[j*POLY_B_TILE_WIDTH+k].

**FSM states: IDLE, ISSUE, WAIT, FIN**
- IDLE:
  - `start` high with `load_en` low: clear i and j, go to ISSUE.
  - `start` high with `load_en` high: start is ignored and the write proceeds.
- ISSUE:
  - Register the tile data and indices, assert `tile_valid`.
  - Go to WAIT next cycle.
- WAIT:
  - Sample `tile_ack`.
  - On ack at the last pair (i=NA-1, j=NB-1): go to FIN.
  - On any other ack: j increments; when j wraps to 0, i increments. Then go to ISSUE.
- FIN: assert `done`, go to IDLE.

**Ignored inputs and held outputs**
- `tile_ack` is ignored outside WAIT.
- `start` is ignored outside IDLE.
- `tile_a`, `tile_b` and the index outputs hold their values between ISSUE cycles and after `done`.

**Reset (rst low)**
- All outputs clear to 0 and the FSM goes to IDLE immediately.
- A mid-job reset abandons the job; the next start replays from pair (0,0).

## Timing
- Accepted start at cycle 0: first `tile_valid` at cycle 1.
- Ack in WAIT at cycle k: next `tile_valid` at k+1.
- Minimum spacing between `tile_valid` pulses is 2 cycles, reached with `tile_ack` tied high.
- Final ack at cycle k: `done` at k+1, `busy` low at k+2.
- `tile_valid`, `done`, `busy` and all data outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
Macro: `TILE_FEEDER_PERF_CNT_EN`.
- **Defined:**
  - `stall_cycles` counts WAIT cycles in which `tile_ack` is low.
  - The count clears on an accepted start and saturates at 2^32-1.
  - The count holds its value after `done`.
  - Reset clears it to 0.
- **Undefined:** `stall_cycles` is tied to 0 and the counter logic is removed.

## Test plan
1. Default parameters, A[n]=n+1, B[n]=2n, `tile_ack` 3 cycles after each `tile_valid`:
   - 256 `tile_valid` pulses.
   - Pulse 0: `tile_a`={1..8}, `tile_b`={0,2,..,14}.
   - Pulse 16: indices (1,0), `tile_a`={9..16}.
   - `done` one cycle after the 256th ack.
   - `stall_cycles`=512 with the macro defined.
2. `tile_ack` held high throughout, start at cycle 0:
   - `tile_valid` at cycles 1,3,…,511.
   - `done` at cycle 513.
   - `stall_cycles`=0.
3. `start` pulsed together with `load_en`=1, load_addr=5, load_data=0xABCD:
   - No `tile_valid`, `busy` stays 0.
   - A[5]=0xABCD, confirmed by a later job's tile 0 `tile_a[5]`.
4. `tile_ack` pulsed in IDLE and during ISSUE:
   - Indices do not advance.
   - Exactly one `tile_valid` per ack received in WAIT.
5. `rst` driven low at pair 37, then a new start:
   - All outputs read 0 during reset.
   - After the new start, first tile indices are (0,0) and tile data still matches the loaded memory.
6. `load_en`=1 while busy, load_addr=0, load_data=0xFFFF:
   - A[0] is unchanged; next job's tile 0 `tile_a[0]`=1.
